// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer with valid/ready flow control.
// Each output channel is a one-entry register slice, so a stalled consumer
// only blocks beats addressed to its own channel.
module demux4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic             pending
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        r_state [4];
  ch_state_t        w_state_nxt [4];
  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       w_load;

  // Per-channel occupancy flags, taken straight from the state registers.
  always_comb begin
    y_valid = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      y_valid[i] = (r_state[i] == FULL);
    end
  end

  // Ready for the addressed channel: it is empty or is being drained this cycle.
  always_comb begin
    in_ready = ~y_valid[sel] | y_ready[sel];
  end

  // One-hot load strobe for the channel that accepts the current beat.
  always_comb begin
    w_load = '0;
    if (in_valid && in_ready) begin
      w_load[sel] = 1'b1;
    end
  end

  // Next-state per channel: a load wins over a consume, so accept+consume stays FULL.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_load[i]) begin
        w_state_nxt[i] = FULL;
      end else if (r_state[i] == FULL && y_ready[i]) begin
        w_state_nxt[i] = EMPTY;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i] <= EMPTY;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // Channel data registers; only the loaded channel captures d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_data[i] <= d;
        end
      end
    end
  end

  // Output mapping and aggregate status.
  always_comb begin
    y0      = r_data[0];
    y1      = r_data[1];
    y2      = r_data[2];
    y3      = r_data[3];
    pending = |y_valid;
  end

endmodule

// File: tb/tb_demux4_reg.sv
// Directed self-checking bench for demux4_reg.
module tb_demux4_reg;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic [1:0] sel;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic       pending;

  int checks;
  int errors;

  demux4_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .sel      (sel),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] get_y(input int k);
    case (k)
      0:       get_y = y0;
      1:       get_y = y1;
      2:       get_y = y2;
      default: get_y = y3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_initial();
    reset = 1'b1; in_valid = 1'b0; d = '0; sel = '0; y_ready = '0;
    #12;
    checks++;
    if (y_valid !== 4'b0000) begin errors++; $display("FAIL reset_y_valid got=%b exp=0000", y_valid); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++;
    if ({y0, y1, y2, y3} !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", {y0, y1, y2, y3}); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_routing();
    logic [7:0] vals [4];
    vals[0] = 8'h03; vals[1] = 8'h0c; vals[2] = 8'h30; vals[3] = 8'hc0;
    y_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; d = vals[k]; sel = 2'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready ch=%0d got=%b exp=1", k, in_ready); end
      tick();
      checks++;
      if (y_valid[k] !== 1'b1) begin errors++; $display("FAIL route_valid ch=%0d got=%b exp=1", k, y_valid[k]); end
      checks++;
      if (get_y(k) !== vals[k]) begin errors++; $display("FAIL route_data ch=%0d got=%h exp=%h", k, get_y(k), vals[k]); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (y_valid !== 4'b0000) begin errors++; $display("FAIL route_drained got=%b exp=0000", y_valid); end
  endtask

  task automatic test_stall();
    y_ready = 4'h0;
    in_valid = 1'b1; d = 8'haa; sel = 2'b10;
    tick();
    checks++;
    if (y2 !== 8'haa || y_valid[2] !== 1'b1) begin errors++; $display("FAIL stall_first got=%h/%b exp=aa/1", y2, y_valid[2]); end
    d = 8'hbb;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++;
    if (y2 !== 8'haa) begin errors++; $display("FAIL stall_hold got=%h exp=aa", y2); end
    y_ready = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    tick();
    checks++;
    if (y2 !== 8'hbb || y_valid[2] !== 1'b1) begin errors++; $display("FAIL stall_second got=%h/%b exp=bb/1", y2, y_valid[2]); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (y_valid[2] !== 1'b0 || y2 !== 8'hbb) begin errors++; $display("FAIL stall_consume got=%h/%b exp=bb/0", y2, y_valid[2]); end
  endtask

  task automatic test_isolation();
    y_ready = 4'h0;
    in_valid = 1'b1; d = 8'h77; sel = 2'b01;
    tick();
    d = 8'h55; sel = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL iso_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (y3 !== 8'h55 || y_valid[3] !== 1'b1) begin errors++; $display("FAIL iso_ch3 got=%h/%b exp=55/1", y3, y_valid[3]); end
    checks++;
    if (y1 !== 8'h77 || y_valid[1] !== 1'b1) begin errors++; $display("FAIL iso_ch1 got=%h/%b exp=77/1", y1, y_valid[1]); end
    // Idle input must not load anything even with d/sel toggling.
    d = 8'hee; sel = 2'b00;
    tick();
    checks++;
    if (y_valid !== 4'b1010 || y0 !== 8'h03) begin errors++; $display("FAIL idle_noload got=%b/%h exp=1010/03", y_valid, y0); end
  endtask

  task automatic test_streaming();
    y_ready = 4'b0001;
    sel = 2'b00; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      d = 8'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat=%0d got=%b exp=1", k, in_ready); end
      tick();
      checks++;
      if (y0 !== 8'(k) || y_valid[0] !== 1'b1) begin errors++; $display("FAIL stream_beat beat=%0d got=%h/%b exp=%h/1", k, y0, y_valid[0], 8'(k)); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (y_valid !== 4'b1010) begin errors++; $display("FAIL stream_end got=%b exp=1010", y_valid); end
  endtask

  task automatic test_drain();
    y_ready = 4'hF; in_valid = 1'b0;
    tick();
    y_ready = 4'h0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h10 + k); sel = 2'(k);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (y_valid !== 4'hF || pending !== 1'b1) begin errors++; $display("FAIL drain_full got=%b/%b exp=1111/1", y_valid, pending); end
    y_ready = 4'hF;
    tick();
    y_ready = 4'h0;
    checks++;
    if (y_valid !== 4'h0 || pending !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b/%b exp=0000/0", y_valid, pending); end
    checks++;
    if ({y0, y1, y2, y3} !== 32'h10111213) begin errors++; $display("FAIL drain_data got=%h exp=10111213", {y0, y1, y2, y3}); end
  endtask

  task automatic test_reset_midrun();
    y_ready = 4'h0; in_valid = 1'b1;
    d = 8'h21; sel = 2'b01; tick();
    d = 8'h43; sel = 2'b11; tick();
    in_valid = 1'b0;
    checks++;
    if (y_valid !== 4'b1010) begin errors++; $display("FAIL midreset_setup got=%b exp=1010", y_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (y_valid !== 4'b0000 || pending !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b/%b exp=0000/0", y_valid, pending); end
    checks++;
    if ({y0, y1, y2, y3} !== 32'h0) begin errors++; $display("FAIL midreset_data got=%h exp=00000000", {y0, y1, y2, y3}); end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; d = 8'h9c; sel = 2'b10;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y2 !== 8'h9c || y_valid !== 4'b0100) begin errors++; $display("FAIL post_reset_accept got=%h/%b exp=9c/0100", y2, y_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset_initial();
    test_routing();
    test_stall();
    test_isolation();
    test_streaming();
    test_drain();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
